// File: rtl/product_accumulator.sv
// Packet accumulator behind the 8x8 multiplier: sums 16-bit products until in_last, then holds sum/count/overflow.
// Optional build macro PRODUCT_ACCUMULATOR_SAT_EN: saturate the sum instead of wrapping on carry out.
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [15:0]      in_product_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_sum_o,
  output logic [CNT_W-1:0] out_count_o,
  output logic             out_overflow_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic             ovf_d;
  logic             accept;

  assign accept = in_valid_i && in_ready_q;

  always_comb begin
    sum_full = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, in_product_i};
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // Once saturated, every later add carries again, so the sum stays pinned.
    acc_d = sum_full[ACC_W] ? {ACC_W{1'b1}} : sum_full[ACC_W-1:0];
`else
    acc_d = sum_full[ACC_W-1:0];
`endif
    ovf_d = ovf_q | sum_full[ACC_W];
    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            if (in_last_i) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = out_valid_q;
  assign out_sum_o      = acc_q;
  assign out_count_o    = cnt_q;
  assign out_overflow_o = ovf_q;

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage directly downstream of the combinational 8x8 multiplier. It accepts the 16-bit `product` one term per cycle over a valid/ready handshake and sums a packet of terms (delimited by `in_last`) into a wide accumulator. It presents the finished sum, term count and overflow flag on a held output handshake. This turns the multiplier into a dot-product / MAC datapath.

## Interface
- `ACC_W`, default 24: accumulator and `out_sum` width; legal range 16..32.
- `CNT_W`, default 8: term counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `in_product` / `in_last` are valid this cycle.
- `in_ready` output 1: block can accept a term this cycle.
- `in_product` input 16: unsigned multiplier product.
- `in_last` input 1: the accepted term is the final term of the packet.
- `out_valid` output 1: result registers hold a finished packet.
- `out_ready` input 1: downstream consumes the result this cycle.
- `out_sum` output ACC_W: packet sum.
- `out_count` output CNT_W: number of terms accepted in the packet.
- `out_overflow` output 1: sticky flag; the sum exceeded 2^ACC_W-1 at some point in the packet.

## Operation
- An input transfer (accept) occurs on a cycle where `in_valid && in_ready`.
- An output transfer (consume) occurs on a cycle where `out_valid && out_ready`.
- The FSM has three states:
  - **IDLE**: `in_ready`=1. Accumulator, counter and flag are all 0. An accept moves the FSM to ACCUM, or straight to DONE if `in_last`=1.
  - **ACCUM**: `in_ready`=1. An accept with `in_last`=0 stays in ACCUM. An accept with `in_last`=1 moves to DONE.
  - **DONE**: `in_ready`=0 and `out_valid`=1. `in_valid` is ignored. A consume clears the accumulator, counter and flag and returns to IDLE.
- Accumulator update on each accept:
  - The next sum is `acc + zero-extended in_product`, computed at ACC_W+1 bits.
  - A carry out of bit ACC_W-1 sets the overflow flag.
  - Without the macro, the stored value wraps modulo 2^ACC_W.
- Counter update on each accept: increment by 1, saturating at 2^CNT_W-1.
  - The counter does not affect packet termination; only `in_last` ends a packet.
- `out_sum`, `out_count` and `out_overflow` are the internal registers, driven directly with no combinational path from the inputs.
  - They are meaningful only while `out_valid`=1.
  - In IDLE and ACCUM they show the partial state.
- `in_ready` and `out_valid` are decoded from the state register only. There is no combinational path from `out_ready` to `in_ready`.

## Timing
- Reset (`rst`=1 at an edge):
  - State becomes IDLE; accumulator, counter and flag become 0.
  - Outputs after that edge: `in_ready`=1, `out_valid`=0, `out_sum`=0, `out_count`=0, `out_overflow`=0.
- Reset mid-packet, or while in DONE, discards the partial or pending result. Reset has priority over every other event in the same cycle.
- Throughput: one term per cycle while in IDLE or ACCUM.
- Latency: last term accepted at edge N gives `out_valid`=1 from cycle N+1.
- The earliest new accept is the cycle after the consume edge, giving one bubble cycle per packet.
- Backpressure: while `out_valid`=1 and `out_ready`=0, all outputs hold stable for any number of cycles.
- A single-term packet (first accept has `in_last`=1) is legal and goes IDLE to DONE directly with count=1.

## Configuration
- Macro: `PRODUCT_ACCUMULATOR_SAT_EN`.
- When defined: on carry out, the accumulator saturates at 2^ACC_W-1 and stays there for the rest of the packet; `out_overflow` is still set.
- When undefined: the accumulator wraps modulo 2^ACC_W and `out_overflow` is set.
- Handshake, FSM and counter behaviour are identical in both builds.

## Test plan
- **Basic packet.** Reset, then accept 100, 200, 300 with `in_last` on the third term and `out_ready`=1.
  - Required: `out_valid`=1 the cycle after the third accept, `out_sum`=600, `out_count`=3, `out_overflow`=0.
  - Required: IDLE and `in_ready`=1 the cycle after the consume.
- **Single term.** Accept 65025 with `in_last`=1.
  - Required: `out_sum`=65025, `out_count`=1, one cycle latency.
- **Backpressure.** Finish a packet with sum 600, then hold `out_ready`=0 for 5 cycles while driving `in_valid`=1 with 7.
  - Required: `in_ready`=0 throughout, outputs stable at 600/3.
  - Required: the 7 is not accumulated until after the consume.
- **Overflow.** With ACC_W=16, accept 65025 then 65025 (last).
  - Required without the macro: `out_sum`=64514, `out_overflow`=1.
  - Required with `PRODUCT_ACCUMULATOR_SAT_EN`: `out_sum`=65535, `out_overflow`=1.
- **Reset mid-packet.** Accept 10 and 20, assert `rst` for one cycle, then accept 5 (last).
  - Required: `out_sum`=5, `out_count`=1, `out_overflow`=0.
- **Back-to-back packets.** Send packets {1,2} and {3} with `out_ready`=1 throughout.
  - Required: results 3/2 then 3/1.
  - Required: exactly one `in_ready`=0 cycle between the packets.
